// File: rtl/sound_pkg.sv
// Shared definitions for the sound path: waveform codes, mixer FSM states, noise LFSR.
package sound_pkg;

  localparam logic [2:0] WAVE_SQU = 3'd0;
  localparam logic [2:0] WAVE_SAW = 3'd1;
  localparam logic [2:0] WAVE_TRI = 3'd2;
  localparam logic [2:0] WAVE_NOI = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_OUT   = 2'd2
  } mix_state_e;

  // Galois LFSR x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/voice_wave_unit.sv
// Combinational waveform shaper: phase/wave/volume/noise -> one voice's contribution.
module voice_wave_unit
  import sound_pkg::*;
#(
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned VOL_W    = 2
) (
  input  logic [PHASE_W-1:0]  phase,
  input  logic [2:0]          wave,
  input  logic [VOL_W-1:0]    vol,
  input  logic [15:0]         lfsr,
  output logic [SAMPLE_W-1:0] contrib_c
);

  localparam int unsigned VOL_MAX = (1 << VOL_W) - 1;

  logic [PHASE_W-1:0]  tri_fold;
  logic [PHASE_W-1:0]  tri_dbl;
  logic [SAMPLE_W-1:0] raw;
  logic [VOL_W-1:0]    shift_amt;

  // Select raw waveform, then attenuate by a right shift (max volume = no shift)
  always_comb begin
    tri_fold  = phase[PHASE_W-1] ? ~phase : phase;
    tri_dbl   = tri_fold << 1;
    raw       = '0;
    case (wave)
      WAVE_SQU: raw = phase[PHASE_W-1] ? '1 : '0;
      WAVE_SAW: raw = phase[PHASE_W-1 -: SAMPLE_W];
      WAVE_TRI: raw = tri_dbl[PHASE_W-1 -: SAMPLE_W];
      WAVE_NOI: raw = lfsr[15 -: SAMPLE_W];
      default:  raw = '0;
    endcase
    shift_amt = VOL_W'(VOL_MAX) - vol;
    contrib_c = raw >> shift_amt;
  end

endmodule

// File: rtl/poly_voice_mixer.sv
// Multi-voice oscillator bank and mixer; one voice per clock after each sample tick.
module poly_voice_mixer
  import sound_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 16,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned VOL_W      = 2,
  parameter int unsigned MIX_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cmd_voice,
  input  logic [PHASE_W-1:0]            cmd_step,
  input  logic [2:0]                    cmd_wave,
  input  logic [VOL_W-1:0]              cmd_vol,
  input  logic                          cmd_gate,
  output logic [SAMPLE_W-1:0]           sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned VIDX_W = $clog2(NUM_VOICES);
  localparam int unsigned ACC_W  = SAMPLE_W + VIDX_W;
  localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

  logic [PHASE_W-1:0]    step_q  [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [2:0]            wave_q  [NUM_VOICES];
  logic [VOL_W-1:0]      vol_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;

  mix_state_e          state_q, state_d;
  logic [VIDX_W-1:0]   voice_q;
  logic [ACC_W-1:0]    acc_q;
  logic [15:0]         lfsr_q;
  logic [SAMPLE_W-1:0] contrib_c;
  logic [SAMPLE_W-1:0] mix_c;
  logic                cmd_accept_c;

  assign cmd_accept_c = cmd_valid && (state_q == ST_IDLE);

  voice_wave_unit #(
    .PHASE_W (PHASE_W),
    .SAMPLE_W(SAMPLE_W),
    .VOL_W   (VOL_W)
  ) u_wave (
    .phase    (phase_q[voice_q]),
    .wave     (wave_q[voice_q]),
    .vol      (vol_q[voice_q]),
    .lfsr     (lfsr_q),
    .contrib_c(contrib_c)
  );

  // Final mix: clamp the wide sum, or divide it by the voice count
  always_comb begin
    mix_c = acc_q[SAMPLE_W-1:0];
    if (MIX_MODE == 0) begin
      if (acc_q[ACC_W-1:SAMPLE_W] != '0) mix_c = '1;
    end else begin
      mix_c = SAMPLE_W'(acc_q >> VIDX_W);
    end
  end

  // Sweep sequencing: IDLE -> one SWEEP cycle per voice -> OUT -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SWEEP;
      ST_SWEEP: if (voice_q == LAST_VOICE) state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Mix datapath, noise source and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voice_q      <= '0;
      acc_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      cmd_ready    <= 1'b1;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      busy         <= (state_d != ST_IDLE);
      cmd_ready    <= (state_d == ST_IDLE);
      if (tick && (state_q != ST_IDLE)) overrun <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            voice_q <= '0;
            acc_q   <= '0;
            lfsr_q  <= lfsr_step(lfsr_q);
          end
        end
        ST_SWEEP: begin
          if (gate_q[voice_q]) acc_q <= acc_q + ACC_W'(contrib_c);
          voice_q <= voice_q + VIDX_W'(1);
        end
        ST_OUT: begin
          sample_out   <= mix_c;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Voice registers: written by commands in IDLE, phases advanced during SWEEP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        step_q[i]  <= '0;
        phase_q[i] <= '0;
        wave_q[i]  <= '0;
        vol_q[i]   <= '0;
      end
      gate_q <= '0;
    end else if (cmd_accept_c) begin
      step_q[cmd_voice] <= cmd_step;
      wave_q[cmd_voice] <= cmd_wave;
      vol_q[cmd_voice]  <= cmd_vol;
      gate_q[cmd_voice] <= cmd_gate;
      if (!gate_q[cmd_voice] && cmd_gate) phase_q[cmd_voice] <= '0;
    end else if ((state_q == ST_SWEEP) && gate_q[voice_q]) begin
      phase_q[voice_q] <= phase_q[voice_q] + step_q[voice_q];
    end
  end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Bench for poly_voice_mixer: saturating and averaging instances driven in parallel.
module tb_poly_voice_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_voice = '0;
  logic [15:0] cmd_step = '0;
  logic [2:0]  cmd_wave = '0;
  logic [1:0]  cmd_vol = '0;
  logic        cmd_gate = 1'b0;

  logic        rdy0, rdy1, val0, val1, busy0, busy1, ovr0, ovr1;
  logic [15:0] out0, out1;

  int n_err = 0;
  int n_chk = 0;
  int vcnt  = 0;

  always #5 clk = ~clk;

  poly_voice_mixer #(.MIX_MODE(0)) u_sum (
    .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_voice(cmd_voice), .cmd_step(cmd_step), .cmd_wave(cmd_wave), .cmd_vol(cmd_vol),
    .cmd_gate(cmd_gate), .sample_out(out0), .sample_valid(val0), .busy(busy0), .overrun(ovr0)
  );

  poly_voice_mixer #(.MIX_MODE(1)) u_avg (
    .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_voice(cmd_voice), .cmd_step(cmd_step), .cmd_wave(cmd_wave), .cmd_vol(cmd_vol),
    .cmd_gate(cmd_gate), .sample_out(out1), .sample_valid(val1), .busy(busy1), .overrun(ovr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (voice-level arithmetic) ----------------
  logic [15:0] m_step [4];
  logic [15:0] m_phase[4];
  logic [2:0]  m_wave [4];
  logic [1:0]  m_vol  [4];
  logic        m_gate [4];
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_out0 = '0, m_out1 = '0, pend0 = '0, pend1 = '0;
  logic        m_valid = 1'b0, m_ovr = 1'b0;
  int          m_busy = 0, cyc = 0, exp_due = -1;

  function automatic int unsigned model_contrib(input logic [2:0] w, input logic [15:0] p,
                                                input logic [1:0] vol, input logic [15:0] l);
    int unsigned raw;
    logic [15:0] f;
    case (w)
      3'd0: raw = p[15] ? 32'd65535 : 32'd0;
      3'd1: raw = 32'(p);
      3'd2: begin
        f   = p[15] ? ~p : p;
        raw = (32'(f) * 2) % 65536;
      end
      3'd3: raw = 32'(l);
      default: raw = 0;
    endcase
    return raw >> (3 - int'(vol));
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_step[i] = '0; m_phase[i] = '0; m_wave[i] = '0; m_vol[i] = '0; m_gate[i] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst) begin
    int unsigned sum;
    bit idle;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_step[i] = '0; m_phase[i] = '0; m_wave[i] = '0; m_vol[i] = '0; m_gate[i] = 1'b0;
      end
      m_lfsr = 16'hACE1; m_out0 = '0; m_out1 = '0; m_valid = 1'b0; m_ovr = 1'b0;
      m_busy = 0; exp_due = -1;
    end else begin
      cyc++;
      m_valid = 1'b0;
      if (exp_due == cyc) begin
        m_out0 = pend0; m_out1 = pend1; m_valid = 1'b1; exp_due = -1;
      end
      idle = (m_busy == 0);
      if (cmd_valid && idle) begin
        if (!m_gate[cmd_voice] && cmd_gate) m_phase[cmd_voice] = '0;
        m_step[cmd_voice] = cmd_step; m_wave[cmd_voice] = cmd_wave;
        m_vol[cmd_voice] = cmd_vol; m_gate[cmd_voice] = cmd_gate;
      end
      if (tick && idle) begin
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        sum = 0;
        for (int v = 0; v < 4; v++) begin
          if (m_gate[v]) begin
            sum += model_contrib(m_wave[v], m_phase[v], m_vol[v], m_lfsr);
            m_phase[v] = m_phase[v] + m_step[v];
          end
        end
        pend0 = (sum > 65535) ? 16'hFFFF : 16'(sum);
        pend1 = 16'(sum / 4);
        exp_due = cyc + 5;
        m_busy = 5;
      end else begin
        if (tick) m_ovr = 1'b1;
        if (!idle) m_busy--;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    if (val0) vcnt++;
    check("sample_out_sum", 32'(out0), 32'(m_out0));
    check("sample_out_avg", 32'(out1), 32'(m_out1));
    check("sample_valid_sum", 32'(val0), 32'(m_valid));
    check("sample_valid_avg", 32'(val1), 32'(m_valid));
    check("busy_sum", 32'(busy0), 32'(m_busy != 0));
    check("busy_avg", 32'(busy1), 32'(m_busy != 0));
    check("cmd_ready_sum", 32'(rdy0), 32'(m_busy == 0));
    check("cmd_ready_avg", 32'(rdy1), 32'(m_busy == 0));
    check("overrun_sum", 32'(ovr0), 32'(m_ovr));
    check("overrun_avg", 32'(ovr1), 32'(m_ovr));
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit          do_cmd;
    logic [1:0]  voice;
    logic [15:0] step;
    logic [2:0]  wave;
    logic [1:0]  vol;
    logic        gate;
    bit          do_tick;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  function automatic vec_t mk(input bit dc, input logic [1:0] v, input logic [15:0] st,
                              input logic [2:0] w, input logic [1:0] vo, input logic g,
                              input bit dt, input logic [15:0] e0, input logic [15:0] e1);
    vec_t r;
    r.do_cmd = dc; r.voice = v; r.step = st; r.wave = w; r.vol = vo; r.gate = g;
    r.do_tick = dt; r.exp0 = e0; r.exp1 = e1;
    return r;
  endfunction

  task automatic send_cmd(input logic [1:0] v, input logic [15:0] st, input logic [2:0] w,
                          input logic [1:0] vo, input logic g);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_voice = v; cmd_step = st; cmd_wave = w; cmd_vol = vo; cmd_gate = g;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_tick(input int gap);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[19];

  initial begin
    int base;
    tbl[0]  = mk(1, 0, 16'h1000, 1, 3, 1, 1, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 16'h1000, 16'h0400);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 16'h2000, 16'h0800);
    tbl[3]  = mk(1, 0, 16'h1000, 1, 1, 1, 1, 16'h0C00, 16'h0300);
    tbl[4]  = mk(1, 0, 16'h1000, 1, 3, 0, 1, 16'h0000, 16'h0000);
    tbl[5]  = mk(1, 0, 16'h8000, 0, 3, 1, 0, 16'h0000, 16'h0000);
    tbl[6]  = mk(1, 1, 16'h8000, 0, 3, 1, 1, 16'h0000, 16'h0000);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 16'h7FFF);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[9]  = mk(1, 0, 16'h8000, 0, 3, 0, 0, 16'h0000, 16'h0000);
    tbl[10] = mk(1, 1, 16'h8000, 0, 3, 0, 0, 16'h0000, 16'h0000);
    tbl[11] = mk(1, 2, 16'h4000, 2, 1, 1, 1, 16'h0000, 16'h0000);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 16'h2000, 16'h0800);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 16'h3FFF, 16'h0FFF);
    tbl[14] = mk(1, 2, 16'h4000, 6, 3, 1, 1, 16'h0000, 16'h0000);
    tbl[15] = mk(1, 2, 16'h4000, 2, 3, 0, 0, 16'h0000, 16'h0000);
    tbl[16] = mk(1, 3, 16'h2000, 1, 3, 1, 1, 16'h0000, 16'h0000);
    tbl[17] = mk(1, 3, 16'h0000, 1, 3, 1, 1, 16'h2000, 16'h0800);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 16'h2000, 16'h0800);

    // Reset held with random inputs
    repeat (8) begin
      @(negedge clk);
      tick = 1'($urandom); cmd_valid = 1'($urandom); cmd_voice = 2'($urandom);
      cmd_step = 16'($urandom); cmd_wave = 3'($urandom); cmd_vol = 2'($urandom);
      cmd_gate = 1'($urandom);
    end
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_sample_out", 32'(out0), 32'd0);
    @(negedge clk);
    tick = 1'b0; cmd_valid = 1'b0;
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].do_cmd)
        send_cmd(tbl[i].voice, tbl[i].step, tbl[i].wave, tbl[i].vol, tbl[i].gate);
      if (tbl[i].do_tick) begin
        pulse_tick(8);
        check($sformatf("vec%0d_sum", i), 32'(out0), 32'(tbl[i].exp0));
        check($sformatf("vec%0d_avg", i), 32'(out1), 32'(tbl[i].exp1));
      end
    end

    // Single saw voice, tick every 20 cycles, through the phase wrap
    do_reset();
    send_cmd(0, 16'h1000, 1, 3, 1);
    for (int k = 0; k < 17; k++) begin
      base = vcnt;
      pulse_tick(18);
      check("saw_one_valid", 32'(vcnt - base), 32'd1);
      if (k == 15) check("saw_F000", 32'(out0), 32'h0000F000);
      if (k == 16) check("saw_wrap", 32'(out0), 32'h00000000);
    end

    // Tick while busy: sticky overrun, one sample only
    base = vcnt;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (12) @(negedge clk);
    check("overrun_single_valid", 32'(vcnt - base), 32'd1);
    check("overrun_set", 32'(ovr0), 32'd1);
    pulse_tick(10);
    check("overrun_sticky", 32'(ovr1), 32'd1);

    // Command while sweeping is refused
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_voice = 0; cmd_step = 16'h0100; cmd_wave = 3; cmd_vol = 0; cmd_gate = 0;
    check("cmd_ready_low_busy", 32'(rdy0), 32'd0);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Gate rising clears phase
    send_cmd(0, 16'h1000, 1, 3, 0);
    send_cmd(0, 16'h1000, 1, 3, 1);
    pulse_tick(8);
    check("regate_phase_zero", 32'(out0), 32'd0);

    // Reset in the middle of a sweep, then a clean noise sweep
    do_reset();
    send_cmd(0, 16'h0000, 3, 3, 1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    base = vcnt;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_valid", 32'(vcnt - base), 32'd0);
    send_cmd(0, 16'h0000, 3, 3, 1);
    pulse_tick(8);
    check("noise_after_reset_sum", 32'(out0), 32'h0000E270);
    check("noise_after_reset_avg", 32'(out1), 32'h0000389C);

    // Random traffic against the model
    repeat (3000) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_voice = 2'($urandom); cmd_step = 16'($urandom); cmd_wave = 3'($urandom);
      cmd_vol = 2'($urandom); cmd_gate = 1'($urandom);
      tick = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    tick = 1'b0; cmd_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/poly_voice_mixer.md
Name: poly_voice_mixer

Overview:
- Multi-voice tone generator and mixer; successor to the single-voice note generator path.
- Holds NUM_VOICES phase-accumulator oscillators. Waveform selection per voice: square, saw, triangle or noise.
- Applies per-voice shift-based volume and mixes the voices in a time-multiplexed loop, one voice per clock, each sample tick.
- Sits between the sample-rate tick generator and the sigma-delta modulator. Its sample_out/sample_valid drive the modulator's sound/start.

Parameters:
- NUM_VOICES, 4, number of voices; power of two, 2..16.
- PHASE_W, 16, phase accumulator and step width.
- SAMPLE_W, 16, output sample width; must satisfy SAMPLE_W <= PHASE_W and SAMPLE_W <= 16.
- VOL_W, 2, per-voice volume width.
- MIX_MODE, 0, mix mode: 0 = saturating sum, 1 = average (sum >> log2(NUM_VOICES)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  sample-rate strobe, one cycle wide.
- cmd_valid  in  1  voice configuration write request.
- cmd_ready  out  1  configuration write accepted when high together with cmd_valid.
- cmd_voice  in  log2(NUM_VOICES)  target voice index.
- cmd_step  in  PHASE_W  phase increment per sample.
- cmd_wave  in  3  waveform: 0 square, 1 saw, 2 triangle, 3 noise, 4-7 silent.
- cmd_vol  in  VOL_W  volume; max value = full scale.
- cmd_gate  in  1  voice enable.
- sample_out  out  SAMPLE_W  mixed unsigned sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high while a mix sweep is in progress.
- overrun  out  1  sticky flag: tick arrived while busy.

Behaviour:
- Reset (rst low, asynchronous) clears all of the following:
  - all voice registers and phases;
  - FSM to IDLE;
  - sample_out, sample_valid, busy, overrun to 0;
  - accumulator to 0;
  - LFSR to 16'hACE1.
- Reset asserted mid-sweep aborts the sweep; no sample_valid is produced for that sweep.
- FSM states: IDLE, SWEEP, OUT.
  - IDLE: tick=1 moves to SWEEP; voice index v=0, acc=0, LFSR advances one step.
  - SWEEP: processes voice v each cycle. After voice NUM_VOICES-1, moves to OUT.
  - OUT: registers the mixed result into sample_out, pulses sample_valid, returns to IDLE.
- Latency: sample_valid rises exactly NUM_VOICES+2 cycles after the cycle tick is high.
- busy = (state != IDLE).
- Per-voice processing in SWEEP, when gate=1:
  - raw is computed from the pre-increment phase; then phase <= phase + step, wrapping mod 2^PHASE_W.
- Per-voice processing when gate=0: contribution is 0 and phase holds.
- Raw waveform, with P = phase:
  - square: all-ones if P[MSB]=1, else 0;
  - saw: P[PHASE_W-1 -: SAMPLE_W];
  - triangle: T = (P[MSB] ? ~P : P) << 1, raw = T[PHASE_W-1 -: SAMPLE_W];
  - noise: LFSR[15 -: SAMPLE_W];
  - codes 4-7: 0.
- Volume: contribution = raw >> (2^VOL_W-1 - vol), logical shift.
- Accumulator width is SAMPLE_W + log2(NUM_VOICES); each voice's contribution is added in its SWEEP cycle.
- OUT, MIX_MODE=0: sample_out = acc overflows SAMPLE_W ? all-ones : acc[SAMPLE_W-1:0].
- OUT, MIX_MODE=1: sample_out = acc >> log2(NUM_VOICES).
- sample_out holds its value between sweeps.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shift right; advances once per accepted tick only.
- Commands:
  - cmd_ready = (state == IDLE).
  - On the cmd_valid && cmd_ready edge, step, wave, vol and gate of cmd_voice are written.
  - If the stored gate was 0 and cmd_gate=1, that voice's phase is cleared to 0. Otherwise phase is untouched.
- Simultaneous command and tick in IDLE: the command is written, the sweep starts on the same edge, and the new settings apply to this sweep.
- Tick while busy: tick is ignored, overrun is set to 1, and overrun stays set until reset. The current sweep is unaffected.
- Step of 0 with gate=1: constant output at the current phase.

Decomposition:
- Shared package sound_pkg holds:
  - waveform code constants (WAVE_SQU=0, WAVE_SAW=1, WAVE_TRI=2, WAVE_NOI=3);
  - FSM state enum;
  - LFSR seed and tap constant.
- One natural sub-module: voice_wave_unit, a combinational function of (phase, wave, vol, lfsr) returning the contribution. It is reusable by later sample-playback voices.
- Voice storage is register arrays inside the top module.

Test Plan:
- Reset/idle: hold rst low with random inputs -> sample_out=0, sample_valid=0, busy=0, overrun=0, cmd_ready=0 only while sweeping.
- Saw, single voice: voice0 step=0x1000, wave=1, vol=3, gate=1, other voices off, tick every 20 cycles -> sample_out sequence 0x0000, 0x1000, 0x2000, ...; wraps 0xF000 -> 0x0000; sample_valid 6 cycles after each tick.
- Saturation vs average: voices 0 and 1 set to square, step=0x8000, vol=3, phase 0x8000 -> MIX_MODE=0 gives 0xFFFF; MIX_MODE=1 gives 0x7FFF.
- Volume and triangle: triangle voice with vol=1 at phase 0x4000 -> raw 0x8000, contribution 0x2000.
- Overrun/handshake: second tick 3 cycles after the first -> overrun=1 and exactly one sample_valid; cmd_valid during the sweep -> cmd_ready=0, registers unchanged; cmd_gate rising on a gated-off voice -> phase reads 0.
- Reset mid-sweep: assert rst 2 cycles after tick -> no sample_valid; LFSR=0xACE1; the next tick produces a normal sweep.
